// File: rtl/dispatch_stage_if.sv
// -----------------------------------------------------------------------------
// dispatch_pkg + dispatch_stage_if
//
// Purpose: shared configuration constants and packet types for the
// rename/dispatch stage, and the interface that bundles every non-clock
// signal of that stage.
//
// Interface signals (direction as seen by the dispatch stage, modport slave):
//   in  instruction_packets    N fetch packets, slot 0 oldest
//   in  instructions_valid     count of valid leading slots
//   in  map_table_restore      checkpointed map table
//   in  restore_valid          mispredict restore this cycle
//   in  b_mask_combinational   branch-mask bits already allocated
//   out branch_stack_entries   new checkpoints, indexed by mask bit
//   out next_b_mask            allocated bits including this cycle's branches
//   in  rob_tail               ROB index for slot 0
//   in  rob_spots / rs_spots   free ROB / RS entries (capped at N)
//   out rob_entries            new ROB entries
//   out rs_entries             new RS entries
//   in  num_regs_available     free physical registers (capped at N)
//   in  next_complete_list     ready bit per physical register
//   in  regs_to_use            next N free registers, allocation order
//   in  free_list_copy         current free-list bitmap
//   out updated_free_list      free list minus this cycle's allocations
//   in  num_issuing            RS entries freed by issue this cycle
//   out num_dispatched         instructions accepted this cycle
//   out dispatch_debug         debug snapshot
// The master modport is the environment side (buffer, ROB, RS, free list).
// -----------------------------------------------------------------------------
package dispatch_pkg;
    localparam int N               = 3;
    localparam int ARCH_REG_SZ     = 32;
    localparam int PHYS_REG_SZ     = 64;
    localparam int ROB_SZ          = 32;
    localparam int B_MASK_WIDTH    = 4;
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);
    localparam int ARCH_IDX        = $clog2(ARCH_REG_SZ);
    localparam int PHYS_REG_IDX    = $clog2(PHYS_REG_SZ);
    localparam int ROB_SZ_BITS     = $clog2(ROB_SZ);
    localparam int SLOT_BITS       = $clog2(N);
    localparam int B_IDX_BITS      = $clog2(B_MASK_WIDTH);

    typedef logic [ARCH_IDX-1:0]        arch_t;
    typedef logic [PHYS_REG_IDX-1:0]    phys_t;
    typedef logic [ROB_SZ_BITS-1:0]     rob_idx_t;
    typedef logic [B_MASK_WIDTH-1:0]    bmask_t;
    typedef logic [NUM_SCALAR_BITS-1:0] count_t;
    typedef logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0] map_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic        is_branch;
        arch_t       rd;
        arch_t       rs1;
        arch_t       rs2;
    } fetch_packet_t;

    typedef struct packed {
        logic  valid;
        arch_t arch_rd;
        phys_t t;
        phys_t t_old;
        logic  complete;
    } rob_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  op;
        logic        is_branch;
        phys_t       t;
        phys_t       src1;
        logic        src1_ready;
        phys_t       src2;
        logic        src2_ready;
        bmask_t      b_mask;
        rob_idx_t    rob_index;
    } rs_packet_t;

    typedef struct packed {
        logic                   valid;
        map_t                   map_table;
        logic [PHYS_REG_SZ-1:0] free_list;
        rob_idx_t               rob_index;
        bmask_t                 b_mask;
    } bs_entry_t;

    typedef struct packed {
        map_t            map_table;
        count_t          num_dispatched;
        phys_t [N-1:0]   t;
        phys_t [N-1:0]   t_old;
    } dispatch_debug_t;
endpackage

interface dispatch_stage_if;
    import dispatch_pkg::*;

    fetch_packet_t [N-1:0]          instruction_packets;
    count_t                         instructions_valid;
    map_t                           map_table_restore;
    logic                           restore_valid;
    bmask_t                         b_mask_combinational;
    bs_entry_t [B_MASK_WIDTH-1:0]   branch_stack_entries;
    bmask_t                         next_b_mask;
    rob_idx_t                       rob_tail;
    count_t                         rob_spots;
    rob_entry_t [N-1:0]             rob_entries;
    rs_packet_t [N-1:0]             rs_entries;
    count_t                         rs_spots;
    count_t                         num_regs_available;
    logic [PHYS_REG_SZ-1:0]         next_complete_list;
    phys_t [N-1:0]                  regs_to_use;
    logic [PHYS_REG_SZ-1:0]         free_list_copy;
    logic [PHYS_REG_SZ-1:0]         updated_free_list;
    count_t                         num_issuing;
    count_t                         num_dispatched;
    dispatch_debug_t                dispatch_debug;

    modport slave (
        input  instruction_packets, instructions_valid, map_table_restore,
               restore_valid, b_mask_combinational, rob_tail, rob_spots,
               rs_spots, num_regs_available, next_complete_list, regs_to_use,
               free_list_copy, num_issuing,
        output branch_stack_entries, next_b_mask, rob_entries, rs_entries,
               updated_free_list, num_dispatched, dispatch_debug
    );

    modport master (
        output instruction_packets, instructions_valid, map_table_restore,
               restore_valid, b_mask_combinational, rob_tail, rob_spots,
               rs_spots, num_regs_available, next_complete_list, regs_to_use,
               free_list_copy, num_issuing,
        input  branch_stack_entries, next_b_mask, rob_entries, rs_entries,
               updated_free_list, num_dispatched, dispatch_debug
    );
endinterface

// File: rtl/dispatch_stage.sv
// -----------------------------------------------------------------------------
// dispatch_stage
//
// Purpose: rename/dispatch stage of an R10K-style out-of-order core. Decides
// how many of the N buffered instructions dispatch this cycle, renames them
// through the architectural map table it owns, and emits ROB entries, RS
// entries and branch-stack checkpoints. A mispredict restore reloads the map.
//
// Ports:
//   clock  in  single clock, state updates on posedge
//   reset  in  asynchronous, active-low; map table returns to identity
//   bus    dispatch_stage_if.slave, all data/handshake signals
//
// Configuration macro: DISPATCH_DEBUG_EN -- when defined, dispatch_debug
// carries the map table, num_dispatched and per-slot T/T_old; otherwise it
// is tied to zero.
// -----------------------------------------------------------------------------
module dispatch_stage
    import dispatch_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    dispatch_stage_if.slave bus
);

    map_t                         map_q;
    map_t                         map_v;
    logic [PHYS_REG_SZ-1:0]       fl_v;
    logic [PHYS_REG_SZ-1:0]       alloc_v;
    bmask_t                       used_v;
    rob_entry_t [N-1:0]           rob_v;
    rs_packet_t [N-1:0]           rs_v;
    bs_entry_t [B_MASK_WIDTH-1:0] bs_v;
    count_t                       count_v;
    count_t                       regs_used;
    int                           limit;
    logic                         stop;
    logic                         has_rd;
    logic                         bit_found;
    logic [B_IDX_BITS-1:0]        free_bit;
    fetch_packet_t                pkt;
    phys_t                        src1;
    phys_t                        src2;
    phys_t                        t_new;

    // Renaming walks the slots in program order; each slot sees the map,
    // free list and mask bits as modified by the older slots. The first slot
    // that cannot dispatch stops the walk, so dispatch is always a prefix.
    // NOTE: blocking assignments here are intentional -- the running copies
    // must be read back within the same pass, and every variable gets a
    // default first so no latch is inferred.
    always_comb begin
        map_v     = map_q;
        fl_v      = bus.free_list_copy;
        alloc_v   = '0;
        used_v    = bus.b_mask_combinational;
        rob_v     = '0;
        rs_v      = '0;
        bs_v      = '0;
        count_v   = '0;
        regs_used = '0;
        pkt       = '0;
        has_rd    = 1'b0;
        bit_found = 1'b0;
        free_bit  = '0;
        src1      = '0;
        src2      = '0;
        t_new     = '0;
        stop      = !reset || bus.restore_valid;

        limit = N;
        if (int'(bus.instructions_valid) < limit) limit = int'(bus.instructions_valid);
        if (int'(bus.rob_spots) < limit)          limit = int'(bus.rob_spots);
        if (int'(bus.rs_spots) + int'(bus.num_issuing) < limit)
            limit = int'(bus.rs_spots) + int'(bus.num_issuing);

        for (int i = 0; i < N; i++) begin
            pkt       = bus.instruction_packets[i];
            has_rd    = (pkt.rd != '0);
            bit_found = 1'b0;
            free_bit  = '0;
            for (int b = 0; b < B_MASK_WIDTH; b++) begin
                if (!bit_found && !used_v[b]) begin
                    bit_found = 1'b1;
                    free_bit  = B_IDX_BITS'(b);
                end
            end

            if (i >= limit)                                     stop = 1'b1;
            if (has_rd && regs_used >= bus.num_regs_available)  stop = 1'b1;
            if (pkt.is_branch && !bit_found)                    stop = 1'b1;

            if (!stop) begin
                src1 = map_v[pkt.rs1];
                src2 = map_v[pkt.rs2];

                rs_v[i].valid      = 1'b1;
                rs_v[i].pc         = pkt.pc;
                rs_v[i].op         = pkt.op;
                rs_v[i].is_branch  = pkt.is_branch;
                rs_v[i].src1       = src1;
                rs_v[i].src2       = src2;
                // A source produced by an older slot of this bundle cannot be
                // complete yet, whatever the stale ready bit says.
                rs_v[i].src1_ready = (pkt.rs1 == '0) ||
                                     (bus.next_complete_list[src1] && !alloc_v[src1]);
                rs_v[i].src2_ready = (pkt.rs2 == '0) ||
                                     (bus.next_complete_list[src2] && !alloc_v[src2]);
                rs_v[i].b_mask     = used_v;
                rs_v[i].rob_index  = rob_idx_t'((int'(bus.rob_tail) + i) % ROB_SZ);

                rob_v[i].valid    = 1'b1;
                rob_v[i].arch_rd  = pkt.rd;
                rob_v[i].complete = 1'b0;

                if (has_rd) begin
                    t_new           = bus.regs_to_use[regs_used[SLOT_BITS-1:0]];
                    rob_v[i].t      = t_new;
                    rob_v[i].t_old  = map_v[pkt.rd];
                    rs_v[i].t       = t_new;
                    map_v[pkt.rd]   = t_new;
                    fl_v[t_new]     = 1'b0;
                    alloc_v[t_new]  = 1'b1;
                    regs_used       = regs_used + count_t'(1);
                end

                // The checkpoint captures state after the branch itself, so
                // it is taken after the rename above.
                if (pkt.is_branch) begin
                    used_v[free_bit]              = 1'b1;
                    bs_v[free_bit].valid          = 1'b1;
                    bs_v[free_bit].map_table      = map_v;
                    bs_v[free_bit].free_list      = fl_v;
                    bs_v[free_bit].rob_index      =
                        rob_idx_t'((int'(bus.rob_tail) + i + 1) % ROB_SZ);
                    bs_v[free_bit].b_mask         = rs_v[i].b_mask;
                end

                count_v = count_v + count_t'(1);
            end
        end
    end

    assign bus.num_dispatched       = count_v;
    assign bus.rob_entries          = rob_v;
    assign bus.rs_entries           = rs_v;
    assign bus.branch_stack_entries = bs_v;
    assign bus.next_b_mask          = used_v;
    assign bus.updated_free_list    = fl_v;

    // NOTE: the map table is a register file that must start as the identity
    // mapping, so unlike a plain data memory it is reset entry by entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < ARCH_REG_SZ; a++) map_q[a] <= phys_t'(a);
        end else if (bus.restore_valid) begin
            map_q <= bus.map_table_restore;
        end else begin
            map_q <= map_v;
        end
    end

`ifdef DISPATCH_DEBUG_EN
    always_comb begin
        bus.dispatch_debug                = '0;
        bus.dispatch_debug.map_table      = map_q;
        bus.dispatch_debug.num_dispatched = count_v;
        for (int i = 0; i < N; i++) begin
            bus.dispatch_debug.t[i]     = rob_v[i].t;
            bus.dispatch_debug.t_old[i] = rob_v[i].t_old;
        end
    end
`else
    assign bus.dispatch_debug = '0;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// -----------------------------------------------------------------------------
// tb_dispatch_stage
//
// Self-checking bench for dispatch_stage: a table of single-cycle dispatch
// limit vectors followed by hand-written multi-cycle sequences (rename chain,
// in-bundle dependency, branch checkpoint, restore, reset, full, ROB wrap).
// Inputs change on the falling edge; outputs are sampled 1-2 ns later.
// -----------------------------------------------------------------------------
module tb_dispatch_stage;
    import dispatch_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    localparam logic [63:0] FREE_DEF     = {32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [63:0] COMPLETE_DEF = {32'h0000_0000, 32'hFFFF_FFFF};

    dispatch_stage_if bus();

    dispatch_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        fetch_packet_t [N-1:0] pk;
        int     valid;
        int     rob;
        int     rs;
        int     iss;
        int     regs;
        bmask_t bm;
        bit     restore;
        int     nd;
        bmask_t nbm;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fetch_packet_t mk(input int rd, input int rs1, input int rs2, input bit br);
        fetch_packet_t p;
        p           = '0;
        p.pc        = 32'h0000_1000 + 32'(rd * 4);
        p.op        = br ? 4'h8 : 4'h1;
        p.is_branch = br;
        p.rd        = arch_t'(rd);
        p.rs1       = arch_t'(rs1);
        p.rs2       = arch_t'(rs2);
        return p;
    endfunction

    function automatic map_t identity();
        map_t m;
        for (int a = 0; a < ARCH_REG_SZ; a++) m[a] = phys_t'(a);
        return m;
    endfunction

    function automatic vec_t mv(input fetch_packet_t p0, input fetch_packet_t p1,
                                input fetch_packet_t p2, input int valid, input int rob,
                                input int rs, input int iss, input int regs,
                                input bmask_t bm, input bit restore, input int nd,
                                input bmask_t nbm);
        vec_t v;
        v.pk[0] = p0; v.pk[1] = p1; v.pk[2] = p2;
        v.valid = valid; v.rob = rob; v.rs = rs; v.iss = iss; v.regs = regs;
        v.bm = bm; v.restore = restore; v.nd = nd; v.nbm = nbm;
        return v;
    endfunction

    task automatic set_idle();
        bus.instruction_packets  = '0;
        bus.instructions_valid   = '0;
        bus.map_table_restore    = identity();
        bus.restore_valid        = 1'b0;
        bus.b_mask_combinational = '0;
        bus.rob_tail             = rob_idx_t'(5);
        bus.rob_spots            = count_t'(3);
        bus.rs_spots             = count_t'(3);
        bus.num_regs_available   = count_t'(3);
        bus.next_complete_list   = COMPLETE_DEF;
        bus.regs_to_use          = {phys_t'(42), phys_t'(41), phys_t'(40)};
        bus.free_list_copy       = FREE_DEF;
        bus.num_issuing          = '0;
    endtask

    // Falling edge, idle inputs, short async reset pulse: identity map.
    task automatic fresh_start();
        @(negedge clock);
        set_idle();
        reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fetch_packet_t add1, add2, add3, add4, st, br;
        map_t          exp_map;

        add1 = mk(1, 2, 3, 0);
        add2 = mk(2, 3, 4, 0);
        add3 = mk(3, 1, 2, 0);
        add4 = mk(4, 1, 2, 0);
        st   = mk(0, 1, 2, 0);
        br   = mk(0, 1, 2, 1);

        //             p0    p1    p2   val rob rs iss regs bm       rst nd nbm
        vecs[0]  = mv(add1, add2, add3, 3, 3, 3, 0, 3, 4'b0000, 0, 3, 4'b0000);
        vecs[1]  = mv(add1, add2, add3, 3, 2, 3, 0, 3, 4'b0000, 0, 2, 4'b0000);
        vecs[2]  = mv(add1, add2, add3, 3, 3, 0, 1, 3, 4'b0000, 0, 1, 4'b0000);
        vecs[3]  = mv(add1, add2, add3, 3, 3, 3, 0, 0, 4'b0000, 0, 0, 4'b0000);
        vecs[4]  = mv(st,   add4, add2, 3, 3, 3, 0, 1, 4'b0000, 0, 2, 4'b0000);
        vecs[5]  = mv(br,   add1, add2, 1, 3, 3, 0, 3, 4'b0111, 0, 1, 4'b1111);
        vecs[6]  = mv(br,   br,   add1, 3, 3, 3, 0, 3, 4'b0111, 0, 1, 4'b1111);
        vecs[7]  = mv(br,   add1, add2, 3, 3, 3, 0, 3, 4'b1111, 0, 0, 4'b1111);
        vecs[8]  = mv(add1, add2, add3, 0, 3, 3, 0, 3, 4'b0010, 0, 0, 4'b0010);
        vecs[9]  = mv(add1, add2, add3, 3, 3, 1, 1, 3, 4'b0000, 0, 2, 4'b0000);
        vecs[10] = mv(br,   add1, br,   3, 3, 3, 0, 3, 4'b0000, 0, 3, 4'b0011);
        vecs[11] = mv(add1, add2, add3, 3, 3, 3, 0, 3, 4'b0001, 1, 0, 4'b0001);

        set_idle();
        #2;
        // Reset state: nothing dispatches and pass-through outputs follow inputs.
        bus.instruction_packets[0] = add1;
        bus.instructions_valid     = count_t'(1);
        bus.b_mask_combinational   = 4'b0100;
        #1;
        check("reset nd",        bus.num_dispatched, 0);
        check("reset rob valid", bus.rob_entries[0].valid, 0);
        check("reset next_b_mask", bus.next_b_mask, 4'b0100);
        check("reset free list", bus.updated_free_list, FREE_DEF);
        reset = 1'b1;

        for (int k = 0; k < 12; k++) begin
            fresh_start();
            bus.instruction_packets  = vecs[k].pk;
            bus.instructions_valid   = count_t'(vecs[k].valid);
            bus.rob_spots            = count_t'(vecs[k].rob);
            bus.rs_spots             = count_t'(vecs[k].rs);
            bus.num_issuing          = count_t'(vecs[k].iss);
            bus.num_regs_available   = count_t'(vecs[k].regs);
            bus.b_mask_combinational = vecs[k].bm;
            bus.restore_valid        = vecs[k].restore;
            #1;
            check($sformatf("vec%0d num_dispatched", k), bus.num_dispatched, vecs[k].nd);
            check($sformatf("vec%0d next_b_mask", k), bus.next_b_mask, vecs[k].nbm);
            for (int i = 0; i < N; i++)
                check($sformatf("vec%0d rob_valid[%0d]", k, i),
                      bus.rob_entries[i].valid, (i < vecs[k].nd));
        end

        // Single add, then the renamed x1 is seen as a source next cycle.
        fresh_start();
        bus.instruction_packets[0] = mk(1, 2, 3, 0);
        bus.instructions_valid     = count_t'(1);
        #1;
        check("add nd",       bus.num_dispatched, 1);
        check("add T",        bus.rob_entries[0].t, 40);
        check("add T_old",    bus.rob_entries[0].t_old, 1);
        check("add src1",     bus.rs_entries[0].src1, 2);
        check("add src2",     bus.rs_entries[0].src2, 3);
        check("add ready1",   bus.rs_entries[0].src1_ready, 1);
        check("add rob_idx",  bus.rs_entries[0].rob_index, 5);
        check("add free list", bus.updated_free_list, FREE_DEF & ~(64'd1 << 40));
        @(negedge clock);
        bus.instruction_packets[0] = mk(7, 1, 0, 0);
        bus.regs_to_use            = {phys_t'(42), phys_t'(41), phys_t'(45)};
        #1;
        check("next map[1] src1", bus.rs_entries[0].src1, 40);
        check("next src1 not ready", bus.rs_entries[0].src1_ready, 0);
        check("next T",        bus.rob_entries[0].t, 45);
        check("next T_old",    bus.rob_entries[0].t_old, 7);
        bus.next_complete_list[40] = 1'b1;
        #1;
        check("next src1 ready", bus.rs_entries[0].src1_ready, 1);

        // In-bundle dependency; stale ready bits must not leak through.
        fresh_start();
        bus.instruction_packets[0] = mk(5, 1, 1, 0);
        bus.instruction_packets[1] = mk(6, 5, 0, 0);
        bus.instructions_valid     = count_t'(2);
        bus.next_complete_list[40] = 1'b1;
        bus.next_complete_list[0]  = 1'b0;
        #1;
        check("dep nd",        bus.num_dispatched, 2);
        check("dep s1 src1",   bus.rs_entries[1].src1, 40);
        check("dep s1 ready1", bus.rs_entries[1].src1_ready, 0);
        check("dep s1 src2",   bus.rs_entries[1].src2, 0);
        check("dep x0 ready",  bus.rs_entries[1].src2_ready, 1);
        check("dep s1 T",      bus.rs_entries[1].t, 41);
        check("dep s1 T_old",  bus.rob_entries[1].t_old, 6);
        check("dep s0 src1",   bus.rs_entries[0].src1, 1);

        // Branch in the middle of a bundle takes the only free bit (3).
        fresh_start();
        bus.b_mask_combinational   = 4'b0111;
        bus.instruction_packets[0] = mk(1, 2, 3, 0);
        bus.instruction_packets[1] = mk(0, 1, 0, 1);
        bus.instruction_packets[2] = mk(2, 1, 3, 0);
        bus.instructions_valid     = count_t'(3);
        exp_map    = identity();
        exp_map[1] = phys_t'(40);
        #1;
        check("br nd",          bus.num_dispatched, 3);
        check("br next_b_mask", bus.next_b_mask, 4'b1111);
        check("br s1 b_mask",   bus.rs_entries[1].b_mask, 4'b0111);
        check("br s2 b_mask",   bus.rs_entries[2].b_mask, 4'b1111);
        check("br s1 src1",     bus.rs_entries[1].src1, 40);
        check("br s2 T",        bus.rs_entries[2].t, 41);
        check("bs3 valid",      bus.branch_stack_entries[3].valid, 1);
        check("bs0 valid",      bus.branch_stack_entries[0].valid, 0);
        check("bs3 rob_index",  bus.branch_stack_entries[3].rob_index, 7);
        check("bs3 b_mask",     bus.branch_stack_entries[3].b_mask, 4'b0111);
        check("bs3 map",        bus.branch_stack_entries[3].map_table, exp_map);
        check("bs3 free list",  bus.branch_stack_entries[3].free_list,
              FREE_DEF & ~(64'd1 << 40));
        check("br free list",   bus.updated_free_list,
              FREE_DEF & ~(64'd1 << 40) & ~(64'd1 << 41));

        // Restore beats dispatch, and the restored map is used next cycle.
        fresh_start();
        bus.instruction_packets[0] = mk(1, 2, 3, 0);
        bus.instructions_valid     = count_t'(1);
        bus.restore_valid          = 1'b1;
        bus.map_table_restore[1]   = phys_t'(50);
        #1;
        check("restore nd",        bus.num_dispatched, 0);
        check("restore rob valid", bus.rob_entries[0].valid, 0);
        check("restore rs valid",  bus.rs_entries[0].valid, 0);
        @(negedge clock);
        bus.restore_valid          = 1'b0;
        bus.instruction_packets[0] = mk(9, 1, 0, 0);
        #1;
        check("restored map[1]",   bus.rs_entries[0].src1, 50);
        check("restored nd",       bus.num_dispatched, 1);

        // Mid-cycle reset: immediate, and it discards the restored mapping.
        bus.b_mask_combinational = 4'b0101;
        reset = 1'b0;
        #1;
        check("midrst nd",          bus.num_dispatched, 0);
        check("midrst next_b_mask", bus.next_b_mask, 4'b0101);
        check("midrst free list",   bus.updated_free_list, FREE_DEF);
        check("midrst rob valid",   bus.rob_entries[0].valid, 0);
        reset = 1'b1;
        #1;
        check("midrst map[1]",      bus.rs_entries[0].src1, 1);

        // Full ROB: nothing dispatches and the map is left untouched.
        fresh_start();
        bus.instruction_packets[0] = mk(1, 2, 3, 0);
        bus.instructions_valid     = count_t'(1);
        bus.rob_spots              = '0;
        #1;
        check("full nd",        bus.num_dispatched, 0);
        check("full free list", bus.updated_free_list, FREE_DEF);
        @(negedge clock);
        bus.rob_spots = count_t'(3);
        #1;
        check("after full T_old", bus.rob_entries[0].t_old, 1);

        // ROB index wrap-around, for RS entries and the branch checkpoint.
        fresh_start();
        bus.rob_tail               = rob_idx_t'(ROB_SZ - 1);
        bus.instruction_packets[0] = mk(1, 2, 3, 0);
        bus.instruction_packets[1] = mk(0, 1, 2, 1);
        bus.instructions_valid     = count_t'(2);
        #1;
        check("wrap nd",         bus.num_dispatched, 2);
        check("wrap s0 rob_idx", bus.rs_entries[0].rob_index, ROB_SZ - 1);
        check("wrap s1 rob_idx", bus.rs_entries[1].rob_index, 0);
        check("wrap bs0 rob_idx", bus.branch_stack_entries[0].rob_index, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Rename/dispatch stage of the R10K-style out-of-order core, between the instruction buffer and the ROB, RS, branch stack and free list. Each cycle it decides how many of the up to N buffered instructions can dispatch and renames them through the architectural map table it owns. It emits ROB entries, RS entries and branch-stack checkpoints, and restores the map table on a mispredict.

## Interface
- N, default 3: superscalar width; NUM_SCALAR_BITS = clog2(N+1).
- ARCH_REG_SZ, default 32: architectural registers.
- PHYS_REG_SZ, default 64: physical registers; PHYS_REG_IDX is clog2(PHYS_REG_SZ) bits.
- ROB_SZ, default 32: ROB depth; ROB_SZ_BITS = clog2(ROB_SZ).
- B_MASK_WIDTH, default 4: branch-stack depth; one mask bit per slot.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- instruction_packets  in  FETCH_PACKET[N]  instructions in program order; slot 0 is oldest.
- instructions_valid  in  NUM_SCALAR_BITS  count of valid leading slots.
- map_table_restore  in  PHYS_REG_IDX[ARCH_REG_SZ]  checkpointed map table.
- restore_valid  in  1  mispredict restore this cycle.
- b_mask_combinational  in  B_MASK_WIDTH  currently allocated branch bits.
- branch_stack_entries  out  BS_ENTRY_PACKET[B_MASK_WIDTH]  new checkpoints, indexed by mask bit.
- next_b_mask  out  B_MASK_WIDTH  b_mask_combinational OR bits allocated this cycle.
- rob_tail  in  ROB_SZ_BITS  ROB index for slot 0.
- rob_spots  in  NUM_SCALAR_BITS  free ROB entries, capped at N.
- rob_entries  out  ROB_ENTRY_PACKET[N]  new ROB entries.
- rs_entries  out  RS_PACKET[N]  new RS entries.
- rs_spots  in  NUM_SCALAR_BITS  free RS entries, capped at N.
- num_regs_available  in  NUM_SCALAR_BITS  free physical registers, capped at N.
- next_complete_list  in  PHYS_REG_SZ  ready bit per physical register.
- regs_to_use  in  PHYS_REG_IDX[N]  next N free registers, in allocation order.
- free_list_copy  in  PHYS_REG_SZ  current free-list bitmap.
- updated_free_list  out  PHYS_REG_SZ  free_list_copy with this cycle's allocations cleared.
- num_issuing  in  NUM_SCALAR_BITS  RS entries freed by issue this cycle.
- num_dispatched  out  NUM_SCALAR_BITS  instructions accepted this cycle.
- dispatch_debug  out  DISPATCH_DEBUG  debug snapshot.

## Operation
- num_dispatched is the largest k such that all of the following hold:
  - k ≤ instructions_valid, k ≤ rob_spots, and k ≤ min(N, rs_spots + num_issuing);
  - the number of slots < k that have a destination (rd ≠ 0) is ≤ num_regs_available;
  - the number of branches among slots < k is ≤ the number of zero bits in b_mask_combinational.
- restore_valid forces num_dispatched = 0.
- Slot i < num_dispatched has its entries valid. All fields of slot i ≥ num_dispatched are don't-care, except valid = 0.
- Renaming, sequential across slots so that slot i sees the map-table writes of slots < i:
  - a destination slot takes the next unused regs_to_use entry;
  - T_old = current map[rd];
  - map[rd] ← T.
- Source operands:
  - Source = map[rs];
  - ready = next_complete_list[Source], forced 0 when Source was allocated by an earlier slot this cycle;
  - rs = x0 is always ready.
- Branch-mask allocation: each branch takes the lowest free mask bit not taken by an earlier slot.
  - The instruction b_mask = b_mask_combinational | bits of earlier branches in the bundle. A branch's own bit is excluded.
  - branch_stack_entries[bit] gets:
    - valid = 1;
    - the map table after all slots up to and including the branch;
    - free_list_copy minus the registers allocated up to and including the branch;
    - rob_tail + branch slot + 1;
    - the branch's b_mask.
- ROB entry: valid, arch rd, T, T_old, complete = 0.
- RS entry:
  - decoded fields, T, sources and ready bits, b_mask;
  - rob_index = (rob_tail + i) mod ROB_SZ, with wrap-around.
- Map-table register update:
  - restore_valid: map table ← map_table_restore;
  - otherwise: map table ← map after renaming the dispatched slots.
- rd = 0 allocates no register and leaves map[0] = 0.

## Timing
- All outputs are combinational from the inputs and the map-table register, with zero-cycle latency.
- The map table updates on the posedge and is visible to renaming next cycle.
- While reset = 0:
  - map table = identity (map[i] = i);
  - num_dispatched = 0;
  - all entry valids = 0;
  - next_b_mask = b_mask_combinational;
  - updated_free_list = free_list_copy.
- Reset asserted mid-operation takes effect immediately. It discards in-flight renames.
- restore_valid together with valid instructions: the restore wins and nothing dispatches.
- A full condition (rob_spots = 0, rs_spots + num_issuing = 0, or no mask bit for the first branch) yields num_dispatched = 0 with no state change.

## Configuration
- DISPATCH_DEBUG_EN defined: dispatch_debug carries the map table, num_dispatched, and the per-slot allocated T/T_old.
- DISPATCH_DEBUG_EN undefined: dispatch_debug is tied to 0. The port remains present.

## Test plan
- Reset, then one valid add x1 = x2 + x3 with all spots = N and regs_to_use[0] = 40:
  - num_dispatched = 1;
  - T = 40, T_old = 1, sources 2 and 3;
  - next cycle the map has map[1] = 40.
- Dependent bundle, x5 = x1 + x1 then x6 = x5 + x0, with regs_to_use = {40, 41}:
  - slot 1 Source1 = 40, not ready;
  - x0 source ready.
- Limits with 3 valid instructions:
  - rob_spots = 2 gives num_dispatched = 2;
  - rs_spots = 0 with num_issuing = 1 gives 1;
  - num_regs_available = 0 gives 0 for instructions that all have a destination.
- Branch with b_mask_combinational = 4'b0111:
  - gets bit 3;
  - next_b_mask = 4'b1111;
  - branch_stack_entries[3] is valid.
- A second branch in the same bundle with no free bit stops dispatch before that branch.
- Restore:
  - restore_valid = 1 with map_table_restore[1] = 50 gives num_dispatched = 0 and map[1] = 50 next cycle.
- Wrap-around:
  - rob_tail = ROB_SZ−1 with 2 dispatched gives rob_index = ROB_SZ−1, then 0.
